multiplier_int8: RTL and testbench

Unsigned 8×8-bit integer multiplier with an 8-bit truncated result and an overflow flag. It uses a sequential shift-add datapath, one multiplier bit per clock, behind a valid/ready input handshake and a held output-valid. It serves as a small arithmetic leaf for datapaths that need an 8-bit product and must detect when the true product exceeds 8 bits.

---
 rtl/multiplier_int8_pkg.sv | 14 +
 rtl/multiplier_int8.sv | 80 ++++++++
 tb/tb_multiplier_int8.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multiplier_int8_pkg.sv
// rtl/multiplier_int8_pkg.sv - shared widths and state encoding for multiplier_int8
package multiplier_int8_pkg;

  localparam int MUL_W = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/multiplier_int8.sv
// rtl/multiplier_int8.sv - sequential shift-add 8x8 unsigned multiplier, 8-bit result plus overflow
module multiplier_int8
  import multiplier_int8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [MUL_W-1:0] y,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MUL_W - 1);

  mul_state_t       state_q;
  logic [ACC_W-1:0] mcand_q;
  logic [MUL_W-1:0] mplier_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [MUL_W-1:0] y_q;
  logic             ovf_q;
  logic             out_valid_q;

  // Partial-product sum for the current multiplier bit; also feeds the result on the last cycle.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (in_valid) begin
            mcand_q     <= {{(ACC_W - MUL_W){1'b0}}, a};
            mplier_q    <= b;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            y_q         <= acc_d[MUL_W-1:0];
            ovf_q       <= |acc_d[ACC_W-1:MUL_W];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q != BUSY);
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_int8.sv
// tb/tb_multiplier_int8.sv - scoreboard bench for multiplier_int8
module tb_multiplier_int8;

  typedef struct {
    logic [7:0] y;
    logic       ovf;
    int         acc_cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       overflow;
  logic       out_valid;

  int   n_cmp;
  int   n_err;
  int   cyc;
  logic prev_ov;
  exp_t exp_q[$];

  multiplier_int8 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a rising out_valid marks a fresh result.
  initial begin
    cyc     = 0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("y", int'(y), int'(e.y));
          check("overflow", int'(overflow), int'(e.ovf));
          check("latency", cyc - e.acc_cyc, 8);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Hand-computed expectations are passed in; garbage keeps in_valid high through BUSY.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ey, input logic eovf, input int garbage);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk); #1;
    while (!in_ready) begin
      waited++;
      if (waited > 20) begin
        check("in_ready_timeout", 0, 1);
        return;
      end
      @(negedge clk); #1;
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    e.y       = ey;
    e.ovf     = eovf;
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    for (int i = 0; i < garbage; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
  endtask

  initial begin
    int          waited;
    logic [15:0] prod;
    logic [7:0]  ra;
    logic [7:0]  rb;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    a        = 8'd0;
    b        = 8'd0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_y", int'(y), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);

    issue(8'd5, 8'd1, 8'd5, 1'b0, 0);
    issue(8'd5, 8'd2, 8'd10, 1'b0, 0);
    issue(8'd5, 8'd5, 8'd25, 1'b0, 0);
    issue(8'd1, 8'd5, 8'd5, 1'b0, 0);
    issue(8'd5, 8'd0, 8'd0, 1'b0, 0);
    issue(8'd0, 8'd5, 8'd0, 1'b0, 0);
    issue(8'd10, 8'd25, 8'd250, 1'b0, 0);
    issue(8'd12, 8'd25, 8'd44, 1'b1, 0);
    issue(8'd255, 8'd255, 8'd1, 1'b1, 0);
    issue(8'd16, 8'd16, 8'd0, 1'b1, 0);
    issue(8'd3, 8'd7, 8'd21, 1'b0, 8);
    issue(8'd200, 8'd2, 8'd144, 1'b1, 8);
    @(negedge clk); #1;
    check("busy_in_ready", int'(in_ready), 1);

    // Abort mid-BUSY: no result may ever appear for this operation.
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    a        = 8'd9;
    b        = 8'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_in_ready_low", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_y", int'(y), 0);
    repeat (12) @(negedge clk);
    check("abort_no_result", int'(out_valid), 0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      prod = 16'(ra) * 16'(rb);
      issue(ra, rb, prod[7:0], (prod > 16'd255), 0);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
